// File: rtl/bsg_link_rx_pkg.sv
// Shared constants and width helpers for the DDR link receive channel.
// Default depth and decimation must match the sender's credit configuration.
package bsg_link_rx_pkg;

    localparam int default_channel_width_lp         = 8;
    localparam int default_pieces_lp                = 2;
    localparam int default_lg_fifo_depth_lp         = 6;
    localparam int default_lg_credit_decimation_lp  = 3;

    typedef enum logic [1:0] {
        VALID_IDLE = 2'b00,
        VALID_BEAT = 2'b11
    } io_valid_e;

    function automatic int beat_width(input int channel_width);
        return 2 * channel_width;
    endfunction

    function automatic int word_width(input int channel_width, input int pieces);
        return pieces * 2 * channel_width;
    endfunction

endpackage

// File: rtl/bsg_link_rx_credit_token.sv
// Credit counter that converts dequeues into decimated token toggles.
// The token is a direct flop output so the sender sees no combinational path.
module bsg_link_rx_credit_token
    import bsg_link_rx_pkg::*;
#(
    parameter int lg_decimation_p = default_lg_credit_decimation_lp
)(
    input  logic clk_i,
    input  logic reset_i,
    input  logic credit_i,
    output logic token_o
);

    logic [lg_decimation_p-1:0] count_q, count_d;
    logic                       token_q, token_d;

    always_comb begin
        count_d = count_q;
        token_d = token_q;
        if (credit_i) begin
            count_d = count_q + 1'b1;
            if (count_q == '1) begin
                token_d = ~token_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            token_q <= 1'b0;
        end else begin
            count_q <= count_d;
            token_q <= token_d;
        end
    end

    assign token_o = token_q;

endmodule

// File: rtl/bsg_link_ddr_channel_rx.sv
// Receive channel: assembles DDR beats into words, buffers them in a
// credit-sized FIFO and returns credits to the sender as token toggles.
module bsg_link_ddr_channel_rx
    import bsg_link_rx_pkg::*;
#(
    parameter int channel_width_p                  = default_channel_width_lp,
    parameter int pieces_p                         = default_pieces_lp,
    parameter int lg_fifo_depth_p                  = default_lg_fifo_depth_lp,
    parameter int lg_credit_to_token_decimation_p  = default_lg_credit_decimation_lp
)(
    input  logic                                           io_clk_i,
    input  logic                                           io_link_reset_i,
    input  logic [1:0]                                     io_valid_i,
    input  logic [2*channel_width_p-1:0]                   io_data_i,
    output logic                                           core_v_o,
    output logic [word_width(channel_width_p, pieces_p)-1:0] core_data_o,
    input  logic                                           core_yumi_i,
    output logic                                           token_clk_r_o,
    output logic                                           overflow_o,
    output logic                                           protocol_err_o
);

    localparam int beat_w_lp  = beat_width(channel_width_p);
    localparam int word_w_lp  = word_width(channel_width_p, pieces_p);
    localparam int depth_lp   = 1 << lg_fifo_depth_p;
    localparam int cnt_w_lp   = (pieces_p > 1) ? $clog2(pieces_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_piece_lp = cnt_w_lp'(pieces_p - 1);

    logic [cnt_w_lp-1:0]                piece_q, piece_d;
    logic [(pieces_p-1)*beat_w_lp-1:0]  hold_q;
    logic [word_w_lp-1:0]               mem_q [depth_lp];
    logic [lg_fifo_depth_p:0]           wr_ptr_q, rd_ptr_q;
    logic                               overflow_q, protocol_err_q;

    logic                 beat_v, mixed_v, last_piece;
    logic                 empty, full, enq, deq, drop;
    logic [word_w_lp-1:0] word;

    assign beat_v     = (io_valid_i == VALID_BEAT);
    assign mixed_v    = (io_valid_i != VALID_BEAT) && (io_valid_i != VALID_IDLE);
    assign last_piece = beat_v && (piece_q == last_piece_lp);
    assign word       = {io_data_i, hold_q};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[lg_fifo_depth_p] != rd_ptr_q[lg_fifo_depth_p])
                && (wr_ptr_q[lg_fifo_depth_p-1:0] == rd_ptr_q[lg_fifo_depth_p-1:0]);
    assign deq   = core_yumi_i && !empty;
    assign enq   = last_piece && (!full || deq);
    assign drop  = last_piece && full && !deq;

    always_comb begin
        piece_d = piece_q;
        if (beat_v) begin
            piece_d = last_piece ? '0 : piece_q + 1'b1;
        end
    end

    always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
        if (io_link_reset_i) begin
            piece_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            overflow_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            piece_q <= piece_d;
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) overflow_q <= 1'b1;
            if (mixed_v) protocol_err_q <= 1'b1;
        end
    end

    // Partial words need no reset: the piece counter restarting at 0 discards them.
    always_ff @(posedge io_clk_i) begin
        if (beat_v && !last_piece) begin
            hold_q[piece_q*beat_w_lp +: beat_w_lp] <= io_data_i;
        end
    end

    // Storage is cleared so an empty FIFO presents a zero head word.
    always_ff @(posedge io_clk_i or posedge io_link_reset_i) begin
        if (io_link_reset_i) begin
            for (int i = 0; i < depth_lp; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enq) begin
            mem_q[wr_ptr_q[lg_fifo_depth_p-1:0]] <= word;
        end
    end

    bsg_link_rx_credit_token #(
        .lg_decimation_p (lg_credit_to_token_decimation_p)
    ) credit_token (
        .clk_i    (io_clk_i),
        .reset_i  (io_link_reset_i),
        .credit_i (deq),
        .token_o  (token_clk_r_o)
    );

    assign core_v_o       = !empty;
    assign core_data_o    = mem_q[rd_ptr_q[lg_fifo_depth_p-1:0]];
    assign overflow_o     = overflow_q;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_bsg_link_ddr_channel_rx.sv
// Directed bench for the DDR link receive channel with default parameters.
module tb_bsg_link_ddr_channel_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  valid = 2'b00;
    logic [15:0] data = 16'h0;
    logic        yumi = 1'b0;
    logic        core_v;
    logic [31:0] core_data;
    logic        token;
    logic        overflow;
    logic        perr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bsg_link_ddr_channel_rx dut (
        .io_clk_i        (clk),
        .io_link_reset_i (rst),
        .io_valid_i      (valid),
        .io_data_i       (data),
        .core_v_o        (core_v),
        .core_data_o     (core_data),
        .core_yumi_i     (yumi),
        .token_clk_r_o   (token),
        .overflow_o      (overflow),
        .protocol_err_o  (perr)
    );

    // Inputs are driven at a negedge, sampled at the posedge, results read at the next negedge.
    task automatic cycle(input logic [1:0] v, input logic [15:0] d, input logic y);
        valid = v;
        data  = d;
        yumi  = y;
        @(negedge clk);
        valid = 2'b00;
        data  = 16'h0;
        yumi  = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int i);
        logic [15:0] k;
        k = 16'(i);
        return {16'hB000 + k, 16'hA000 + k};
    endfunction

    task automatic send_word(input int i, input logic y_last);
        logic [31:0] w;
        w = word_of(i);
        cycle(2'b11, w[15:0], 1'b0);
        cycle(2'b11, w[31:16], y_last);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL reset_v got %0b want 0", core_v); end
        n_checks++; if (core_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", core_data); end
        n_checks++; if (token !== 1'b0) begin n_fail++; $display("FAIL reset_token got %0b want 0", token); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %0b want 0", perr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        cycle(2'b11, 16'h1111, 1'b0);
        n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL basic_v_early got %0b want 0", core_v); end
        cycle(2'b11, 16'h2222, 1'b0);
        n_checks++; if (core_v !== 1'b1) begin n_fail++; $display("FAIL basic_v got %0b want 1", core_v); end
        n_checks++; if (core_data !== 32'h2222_1111) begin n_fail++; $display("FAIL basic_data got %h want 22221111", core_data); end
        cycle(2'b00, 16'h0, 1'b1);
        n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL basic_v_after_yumi got %0b want 0", core_v); end
    endtask

    task automatic test_idle_gap();
        do_reset();
        cycle(2'b11, 16'h1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(2'b00, 16'h0, 1'b0);
            n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL gap_v idle %0d got %0b want 0", i, core_v); end
        end
        cycle(2'b11, 16'h2222, 1'b0);
        n_checks++; if (core_v !== 1'b1) begin n_fail++; $display("FAIL gap_v got %0b want 1", core_v); end
        n_checks++; if (core_data !== 32'h2222_1111) begin n_fail++; $display("FAIL gap_data got %h want 22221111", core_data); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 64; i++) send_word(i, 1'b0);
        n_checks++; if (core_v !== 1'b1) begin n_fail++; $display("FAIL full_v got %0b want 1", core_v); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow got %0b want 0", overflow); end
        n_checks++; if (core_data !== word_of(0)) begin n_fail++; $display("FAIL full_head got %h want %h", core_data, word_of(0)); end
        send_word(64, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        n_checks++; if (core_data !== word_of(0)) begin n_fail++; $display("FAIL ovf_head got %h want %h", core_data, word_of(0)); end
        for (int i = 0; i < 64; i++) begin
            n_checks++; if (core_data !== word_of(i)) begin n_fail++; $display("FAIL ovf_drain %0d got %h want %h", i, core_data, word_of(i)); end
            cycle(2'b00, 16'h0, 1'b1);
        end
        n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %0b want 0", core_v); end
        n_checks++; if (token !== 1'b0) begin n_fail++; $display("FAIL ovf_token got %0b want 0", token); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    endtask

    task automatic test_full_with_yumi();
        do_reset();
        for (int i = 0; i < 64; i++) send_word(i, 1'b0);
        send_word(64, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fy_overflow got %0b want 0", overflow); end
        n_checks++; if (core_data !== word_of(1)) begin n_fail++; $display("FAIL fy_head got %h want %h", core_data, word_of(1)); end
        for (int i = 1; i <= 64; i++) begin
            n_checks++; if (core_data !== word_of(i)) begin n_fail++; $display("FAIL fy_drain %0d got %h want %h", i, core_data, word_of(i)); end
            cycle(2'b00, 16'h0, 1'b1);
        end
        n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL fy_empty got %0b want 0", core_v); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fy_overflow_end got %0b want 0", overflow); end
    endtask

    task automatic test_token();
        logic exp;
        do_reset();
        for (int i = 0; i < 24; i++) send_word(i, 1'b0);
        n_checks++; if (token !== 1'b0) begin n_fail++; $display("FAIL tok_initial got %0b want 0", token); end
        for (int n = 1; n <= 24; n++) begin
            cycle(2'b00, 16'h0, 1'b1);
            exp = ((n / 8) % 2) == 1;
            n_checks++; if (token !== exp) begin n_fail++; $display("FAIL tok_after_yumi %0d got %0b want %0b", n, token, exp); end
        end
        cycle(2'b00, 16'h0, 1'b1);
        n_checks++; if (token !== 1'b1) begin n_fail++; $display("FAIL tok_empty_yumi got %0b want 1", token); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (token !== 1'b0) begin n_fail++; $display("FAIL tok_async_reset got %0b want 0", token); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_protocol_reset();
        do_reset();
        cycle(2'b11, 16'h1111, 1'b0);
        cycle(2'b01, 16'hDEAD, 1'b0);
        n_checks++; if (perr !== 1'b1) begin n_fail++; $display("FAIL perr_set got %0b want 1", perr); end
        n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL perr_v got %0b want 0", core_v); end
        cycle(2'b11, 16'h2222, 1'b0);
        n_checks++; if (core_v !== 1'b1) begin n_fail++; $display("FAIL perr_word_v got %0b want 1", core_v); end
        n_checks++; if (core_data !== 32'h2222_1111) begin n_fail++; $display("FAIL perr_word got %h want 22221111", core_data); end
        cycle(2'b11, 16'h3333, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL arst_v got %0b want 0", core_v); end
        n_checks++; if (core_data !== 32'h0) begin n_fail++; $display("FAIL arst_data got %h want 0", core_data); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL arst_perr got %0b want 0", perr); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL arst_overflow got %0b want 0", overflow); end
        n_checks++; if (token !== 1'b0) begin n_fail++; $display("FAIL arst_token got %0b want 0", token); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cycle(2'b11, 16'h4444, 1'b0);
        n_checks++; if (core_v !== 1'b0) begin n_fail++; $display("FAIL post_rst_v_early got %0b want 0", core_v); end
        cycle(2'b11, 16'h5555, 1'b0);
        n_checks++; if (core_v !== 1'b1) begin n_fail++; $display("FAIL post_rst_v got %0b want 1", core_v); end
        n_checks++; if (core_data !== 32'h5555_4444) begin n_fail++; $display("FAIL post_rst_data got %h want 55554444", core_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_gap();
        test_overflow();
        test_full_with_yumi();
        test_token();
        test_protocol_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
